matmul_operand_loader: RTL

Upstream feeder for the 2x2-by-2x1 floating-point matrix-multiply stage.
- Accepts a serial stream of IEEE-style words (exp_width + mant_width bits) over a valid/ready handshake.
- Assembles the words into a persistent weight set (a11, a12, a21, a22) and an input vector (b1, b2).
- Presents all six operands as stable registered values with an operands_valid/operands_ack handshake, so the combinational matmul sees held inputs.
- Weights are retained across vectors, so a layer can stream many vectors against one weight load.

---
 rtl/matmul_operand_loader.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/matmul_operand_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : matmul_operand_loader
// Description : Operand feeder for the 2x2-by-2x1 floating-point matmul stage.
//               Assembles a serial valid/ready word stream into a persistent
//               weight set (a11..a22) and an input vector (b1, b2), then holds
//               all six operands stable under an operands_valid/operands_ack
//               handshake. Weights stay resident across vectors.
// Ports       : clk, rst            - clock, synchronous active-high reset
//               in_valid/in_ready   - upstream word handshake
//               in_data             - operand word (EXP_WIDTH+MANT_WIDTH bits)
//               in_is_weight        - 1 = weight word, 0 = vector word
//               a11,a12,a21,a22     - registered weights
//               b1,b2               - registered vector
//               operands_valid/ack  - downstream operand-set handshake
//               weights_loaded      - all four weights present
//               vector_count        - operand sets acknowledged (wraps)
// Revision    : 1.0 - initial release
// ============================================================================
module matmul_operand_loader #(
    parameter int EXP_WIDTH  = 8,
    parameter int MANT_WIDTH = 24,
    localparam int W         = EXP_WIDTH + MANT_WIDTH
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    input  logic         in_is_weight,
    output logic [W-1:0] a11,
    output logic [W-1:0] a12,
    output logic [W-1:0] a21,
    output logic [W-1:0] a22,
    output logic [W-1:0] b1,
    output logic [W-1:0] b2,
    output logic         operands_valid,
    input  logic         operands_ack,
    output logic         weights_loaded,
    output logic [15:0]  vector_count
);

    localparam logic [0:0] C_STATE_FILL = 1'b0;
    localparam logic [0:0] C_STATE_HOLD = 1'b1;

    logic [0:0]   r_state;
    logic [1:0]   r_w_cnt;
    logic         r_v_cnt;
    logic         r_vec_complete;
    logic         r_weights_loaded;
    logic [15:0]  r_vector_count;
    logic [W-1:0] r_a11, r_a12, r_a21, r_a22, r_b1, r_b2;

    logic w_in_ready;
    logic w_accept;
    logic w_take_weight;
    logic w_take_vec;
    logic w_wl_next;
    logic w_vc_next;

    // Ready is also gated by rst so nothing is accepted in the reset cycle,
    // whatever state the register happened to be in.
    assign w_in_ready = (r_state == C_STATE_FILL) && !rst;

    always_comb begin
        w_accept      = in_valid && w_in_ready;
        w_take_weight = w_accept && in_is_weight;
        w_take_vec    = w_accept && !in_is_weight;

        // Writing slot 0 starts a new weight set and invalidates the old one;
        // only writing slot 3 makes the set complete again.
        w_wl_next = r_weights_loaded;
        if (w_take_weight) begin
            if (r_w_cnt == 2'd3) begin
                w_wl_next = 1'b1;
            end else if (r_w_cnt == 2'd0) begin
                w_wl_next = 1'b0;
            end
        end

        w_vc_next = r_vec_complete | (w_take_vec && r_v_cnt);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state          <= C_STATE_FILL;
            r_w_cnt          <= 2'd0;
            r_v_cnt          <= 1'b0;
            r_vec_complete   <= 1'b0;
            r_weights_loaded <= 1'b0;
            r_vector_count   <= 16'd0;
            r_a11            <= '0;
            r_a12            <= '0;
            r_a21            <= '0;
            r_a22            <= '0;
            r_b1             <= '0;
            r_b2             <= '0;
        end else if (r_state == C_STATE_FILL) begin
            if (w_take_weight) begin
                case (r_w_cnt)
                    2'd0:    r_a11 <= in_data;
                    2'd1:    r_a12 <= in_data;
                    2'd2:    r_a21 <= in_data;
                    default: r_a22 <= in_data;
                endcase
                r_w_cnt <= r_w_cnt + 2'd1;
            end
            if (w_take_vec) begin
                if (r_v_cnt) begin
                    r_b2 <= in_data;
                end else begin
                    r_b1 <= in_data;
                end
                r_v_cnt <= ~r_v_cnt;
            end
            r_weights_loaded <= w_wl_next;
            r_vec_complete   <= w_vc_next;
            // Decide on post-update flags so the completing word itself
            // triggers issue with one cycle of latency.
            if (w_wl_next && w_vc_next) begin
                r_state <= C_STATE_HOLD;
            end
        end else begin
            if (operands_ack) begin
                r_state        <= C_STATE_FILL;
                r_vec_complete <= 1'b0;
                r_v_cnt        <= 1'b0;
                r_vector_count <= r_vector_count + 16'd1;
            end
        end
    end

    assign in_ready       = w_in_ready;
    assign operands_valid = (r_state == C_STATE_HOLD);
    assign weights_loaded = r_weights_loaded;
    assign vector_count   = r_vector_count;
    assign a11            = r_a11;
    assign a12            = r_a12;
    assign a21            = r_a21;
    assign a22            = r_a22;
    assign b1             = r_b1;
    assign b2             = r_b2;

endmodule
`default_nettype wire
